cell_config_loader: RTL and testbench
=====================================

Name: cell_config_loader

Overview:
- Upstream configuration stage for the logic-cell array.
- Accepts a stream of 4-bit cell RAM words from the Linux-side bus over a valid/ready handshake.
- Drives a shared `cell_ram` bus and a one-hot per-cell `cell_write_en` strobe, so each cell latches its word on the strobe's rising edge.
- Sits between the HPS bridge and the cell grid; one load pass programs cells 0..NUM_CELLS-1 in index order.

Parameters:
- NUM_CELLS, 16, number of logic cells driven; legal range 1..256.
- IDX_W, 4, width of the cell index counter; must satisfy 2^IDX_W >= NUM_CELLS.
- RAM_W, 4, width of one cell RAM word: [STATE | NULL | RAM1 | RAM0].

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to begin a load pass; sampled only in IDLE.
- cfg_data  input  RAM_W  next cell RAM word.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader can accept cfg_data this cycle.
- cell_ram  output  RAM_W  shared RAM word to all cells.
- cell_write_en  output  NUM_CELLS  one-hot write strobe, bit i = cell i.
- cell_idx  output  IDX_W  index of the cell currently being programmed.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse when the last cell is written.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; cfg_ready=0, cell_ram=0, cell_write_en=0, cell_idx=0, busy=0, done=0. Reset overrides all other inputs.
- States: IDLE, LOAD, SETUP, STROBE, RELEASE, DONE. All outputs are registered.
- IDLE:
  - start=1 -> LOAD, busy=1, cell_idx=0.
  - cfg_valid is ignored; cfg_ready=0.
- LOAD:
  - cfg_ready=1.
  - cfg_valid=1 (handshake) -> latch cfg_data into cell_ram, go to SETUP.
  - cfg_valid=0 -> stay in LOAD indefinitely; no timeout.
- SETUP: cfg_ready=0; assert cell_write_en[cell_idx]=1; go to STROBE.
- STROBE: deassert cell_write_en to all-zero; go to RELEASE.
- RELEASE:
  - cell_idx==NUM_CELLS-1 -> go to DONE.
  - Otherwise cell_idx+1 -> go to LOAD.
- DONE: done=1 for exactly one cycle, busy=0, cell_idx=0 -> go to IDLE.
- Timing and hold rules:
  - cell_ram is stable from the handshake edge until the next handshake edge. This gives one full cycle of setup before the strobe's rising edge and one cycle of hold after its falling edge.
  - cell_write_en is high for exactly one cycle per cell, with at most one bit set at any time.
- Throughput: 4 cycles per cell minimum when cfg_valid is held high. A full pass takes 4*NUM_CELLS + 2 cycles from start to the done pulse.
- start while busy=1 is ignored; there is no restart mid-pass.
- NUM_CELLS=1: the single pass goes LOAD->SETUP->STROBE->RELEASE->DONE; cell_idx never increments.
- Reset mid-pass:
  - Any asserted write_en clears on the same edge.
  - Cells already programmed keep their config, because cells have no reset.
  - The next pass begins again at cell 0.
- cell_idx never exceeds NUM_CELLS-1; there is no wrap past the last cell.

Optional Feature:
- Macro: CFG_READBACK_EN.
- Defined:
  - Adds input rd_idx[IDX_W-1:0] and output rd_data[RAM_W-1:0].
  - A shadow array stores each word on its SETUP cycle.
  - rd_data is registered, valid 1 cycle after rd_idx.
  - Reset clears the shadow array to 0.
  - rd_idx >= NUM_CELLS returns 0.
- Undefined: no shadow storage; rd_idx and rd_data ports are absent.

Test Plan:
- Reset: rst_n=0 for 2 cycles with start=1 and cfg_valid=1 -> all outputs 0, state stays IDLE, cfg_ready=0.
- Full pass, NUM_CELLS=16, cfg_valid held high, words 4'h0..4'hF -> cell_write_en walks bit0..bit15 one cycle each, 4 cycles apart. cell_ram equals the word for that cell on every strobe cycle. done pulses exactly 66 cycles after start.
- Stalled source: deassert cfg_valid for 10 cycles before cell 5 -> cfg_ready stays 1 and cell_write_en stays 0 throughout. Cell 5 is then strobed with the word presented at release; no duplicates or skips.
- Ignored start: pulse start at cell 7 -> pass continues unchanged, single done pulse, busy drops only at done.
- Reset mid-pass: assert rst_n=0 on the SETUP->STROBE edge of cell 3 -> cell_write_en=0 the next cycle. A new start reprograms from cell 0 (first strobe on bit0).
- CFG_READBACK_EN: after the full pass with words 4'h0..4'hF, rd_idx=9 -> rd_data=4'h9 one cycle later; rd_idx=15 -> 4'hF.

Source files
------------

// File: rtl/cell_config_loader.sv
// cell_config_loader
// Streams 4-bit cell RAM words from the HPS-side bus into the logic-cell
// array. A load pass programs cells 0..NUM_CELLS-1 in index order. The shared
// cell_ram bus is driven together with a one-hot cell_write_en strobe, so each
// cell latches its word on its strobe's rising edge.
//
// Ports:
//   clk            system clock, all logic on posedge
//   rst_n          synchronous active-low reset
//   start          one-cycle request to begin a pass (sampled only when idle)
//   cfg_data       next cell RAM word [STATE | NULL | RAM1 | RAM0]
//   cfg_valid      cfg_data valid
//   cfg_ready      loader accepts cfg_data this cycle
//   cell_ram       shared RAM word to all cells
//   cell_write_en  one-hot write strobe, bit i = cell i
//   cell_idx       index of the cell being programmed
//   busy           high from start acceptance until done
//   done           one-cycle pulse after the last cell is written
//   rd_idx         (CFG_READBACK_EN) shadow readback index
//   rd_data        (CFG_READBACK_EN) shadow word, one cycle after rd_idx
//
// Optional feature macro: CFG_READBACK_EN adds a shadow copy of every word
// written, readable through rd_idx/rd_data.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start
// LOAD    | cfg_ready high, waiting for a cfg_valid handshake
// SETUP   | cell_ram settled for one cycle; strobe rises on exit
// STROBE  | strobe high for this cycle; falls on exit
// RELEASE | cell_ram held one more cycle; advance index or finish
// DONE    | last cell written; done pulses and busy drops on exit
module cell_config_loader #(
  parameter int NUM_CELLS = 16,
  parameter int IDX_W     = 4,
  parameter int RAM_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [RAM_W-1:0]     cfg_data,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic [RAM_W-1:0]     cell_ram,
  output logic [NUM_CELLS-1:0] cell_write_en,
  output logic [IDX_W-1:0]     cell_idx,
  output logic                 busy,
  output logic                 done
`ifdef CFG_READBACK_EN
  ,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [RAM_W-1:0]     rd_data
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_STROBE,
    S_RELEASE,
    S_DONE
  } state_t;

  localparam logic [NUM_CELLS-1:0] LP_ONE   = NUM_CELLS'(1);
  localparam logic [IDX_W-1:0]     LP_LAST  = IDX_W'(NUM_CELLS - 1);

  state_t               r_state;
  logic                 r_cfg_ready;
  logic [RAM_W-1:0]     r_cell_ram;
  logic [NUM_CELLS-1:0] r_write_en;
  logic [IDX_W-1:0]     r_cell_idx;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_state_nxt;
  logic                 w_ready_nxt;
  logic [RAM_W-1:0]     w_ram_nxt;
  logic [NUM_CELLS-1:0] w_we_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output values; every output is registered below.
  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = r_cfg_ready;
    w_ram_nxt   = r_cell_ram;
    w_we_nxt    = '0;
    w_idx_nxt   = r_cell_idx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_busy_nxt  = 1'b1;
          w_idx_nxt   = '0;
          w_ready_nxt = 1'b1;
        end
      end
      S_LOAD: begin
        if (cfg_valid) begin
          w_ram_nxt   = cfg_data;
          w_ready_nxt = 1'b0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        w_we_nxt    = LP_ONE << r_cell_idx;
        w_state_nxt = S_STROBE;
      end
      S_STROBE: begin
        w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (r_cell_idx == LP_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_cell_idx + 1'b1;
          w_ready_nxt = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_idx_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cfg_ready <= 1'b0;
      r_cell_ram  <= '0;
      r_write_en  <= '0;
      r_cell_idx  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cfg_ready <= w_ready_nxt;
      r_cell_ram  <= w_ram_nxt;
      r_write_en  <= w_we_nxt;
      r_cell_idx  <= w_idx_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign cfg_ready     = r_cfg_ready;
  assign cell_ram      = r_cell_ram;
  assign cell_write_en = r_write_en;
  assign cell_idx      = r_cell_idx;
  assign busy          = r_busy;
  assign done          = r_done;

`ifdef CFG_READBACK_EN
  logic [RAM_W-1:0] r_shadow [NUM_CELLS];
  logic [RAM_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        r_shadow[i] <= '0;
      end
      r_rd_data <= '0;
    end else begin
      if (r_state == S_SETUP) begin
        r_shadow[r_cell_idx] <= r_cell_ram;
      end
      // Indices past the last cell read as zero.
      r_rd_data <= (int'(rd_idx) < NUM_CELLS) ? r_shadow[rd_idx] : '0;
    end
  end

  assign rd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_cell_config_loader.sv
module tb_cell_config_loader;
  localparam int N  = 16;
  localparam int IW = 4;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [RW-1:0] cell_ram;
  logic [N-1:0]  cell_write_en;
  logic [IW-1:0] cell_idx;
  logic          busy;
  logic          done;
`ifdef CFG_READBACK_EN
  logic [IW-1:0] rd_idx = '0;
  logic [RW-1:0] rd_data;
`endif

  cell_config_loader #(.NUM_CELLS(N), .IDX_W(IW), .RAM_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cell_ram(cell_ram),
    .cell_write_en(cell_write_en), .cell_idx(cell_idx), .busy(busy),
    .done(done)
`ifdef CFG_READBACK_EN
    , .rd_idx(rd_idx), .rd_data(rd_data)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h edge=%0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a pass is a sequence of accepted words. After a word is
  // accepted at edge h, the strobe is visible after edge h+1 and gone after
  // h+2; the next word may be taken from edge h+4 on; after the last word
  // the done pulse appears after edge h+4.
  bit            m_busy = 0;
  bit            m_wait = 0;
  bit            m_done = 0;
  int            m_cell = 0;
  int            m_hs = -100;
  logic [RW-1:0] m_ram = '0;
  logic [N-1:0]  m_we = '0;
`ifdef CFG_READBACK_EN
  logic [RW-1:0] m_shadow [N];
  logic [RW-1:0] m_rd = '0;
`endif

  always @(posedge clk) begin
    cyc++;
    m_done = 0;
`ifdef CFG_READBACK_EN
    m_rd = (int'(rd_idx) < N) ? m_shadow[rd_idx] : '0;
`endif
    if (!rst_n) begin
      m_busy = 0; m_wait = 0; m_cell = 0; m_ram = '0; m_hs = -100;
`ifdef CFG_READBACK_EN
      for (int i = 0; i < N; i++) m_shadow[i] = '0;
      m_rd = '0;
`endif
    end else if (!m_busy) begin
      if (start) begin m_busy = 1; m_cell = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (cfg_valid) begin m_ram = cfg_data; m_hs = cyc; m_wait = 0; end
    end else begin
`ifdef CFG_READBACK_EN
      if (cyc - m_hs == 1) m_shadow[m_cell] = m_ram;
`endif
      if (cyc - m_hs == 3 && m_cell < N - 1) begin
        m_cell++; m_wait = 1;
      end else if (cyc - m_hs == 4) begin
        m_busy = 0; m_cell = 0; m_done = 1;
      end
    end
    m_we = '0;
    if (m_busy && !m_wait && (cyc - m_hs == 1)) m_we[m_cell] = 1'b1;
  end

  int s_idx[$];
  int s_ram[$];
  int s_edge[$];
  int done_edges[$];

  function automatic int oh_idx(input logic [N-1:0] v);
    int r = -1;
    int n = 0;
    for (int i = 0; i < N; i++) if (v[i]) begin r = i; n++; end
    return (n == 1) ? r : -2;
  endfunction

  always @(negedge clk) begin
    check("cfg_ready", 32'(cfg_ready), 32'(m_busy && m_wait));
    check("cell_ram", 32'(cell_ram), 32'(m_ram));
    check("write_en", 32'(cell_write_en), 32'(m_we));
    check("cell_idx", 32'(cell_idx), 32'(m_cell));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
`ifdef CFG_READBACK_EN
    check("rd_data", 32'(rd_data), 32'(m_rd));
`endif
    if (cell_write_en != '0) begin
      s_idx.push_back(oh_idx(cell_write_en));
      s_ram.push_back(int'(cell_ram));
      s_edge.push_back(cyc);
    end
    if (done === 1'b1) done_edges.push_back(cyc);
  end

  logic [RW-1:0] wds [N];

  task automatic run_pass(input int vprob, input int stall_cell, input int stall_len,
                          input int xstart_cell, input int abort_cell, input int sprob,
                          output int lat, output bit aborted);
    int stalled = 0;
    bit xdone = 0;
    int start_edge;
    int guard = 0;
    s_idx.delete(); s_ram.delete(); s_edge.delete(); done_edges.delete();
    lat = -1;
    aborted = 0;
    @(negedge clk);
    start = 1'b1; cfg_valid = 1'b0; start_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (guard < 3000) begin
      guard++;
      start = 1'b0;
      if (done_edges.size() > 0) break;
      if (abort_cell >= 0 && m_busy && !m_wait && m_cell == abort_cell && cyc == m_hs) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_we_clear", 32'(cell_write_en), 32'h0);
        rst_n = 1'b1;
        aborted = 1;
        break;
      end
      if (m_wait && m_cell == stall_cell && stalled < stall_len) begin
        cfg_valid = 1'b0; stalled++;
      end else begin
        cfg_valid = ($urandom_range(99) < vprob);
      end
      cfg_data = m_wait ? wds[m_cell] : RW'($urandom);
      if (m_busy && m_cell == xstart_cell && !xdone) begin
        start = 1'b1; xdone = 1;
      end else if (m_busy && $urandom_range(99) < sprob) begin
        start = 1'b1;
      end
`ifdef CFG_READBACK_EN
      rd_idx = IW'($urandom);
`endif
      @(negedge clk);
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    if (done_edges.size() > 0) lat = done_edges[0] - start_edge + 1;
    else if (!aborted) check("pass_timeout", 32'(guard), 32'h0);
  endtask

  task automatic check_pass(input string nm);
    check({nm, "_strobes"}, 32'(s_idx.size()), 32'(N));
    check({nm, "_dones"}, 32'(done_edges.size()), 32'd1);
    for (int k = 0; k < N && k < s_idx.size(); k++) begin
      check({nm, "_strobe_idx"}, 32'(s_idx[k]), 32'(k));
      check({nm, "_strobe_ram"}, 32'(s_ram[k]), 32'(wds[k]));
    end
  endtask

  initial begin
    int lat;
    bit ab;
    // Reset with start and cfg_valid asserted.
    rst_n = 1'b0; start = 1'b1; cfg_valid = 1'b1; cfg_data = 4'hA;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(cfg_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_we", 32'(cell_write_en), 32'h0);
    check("rst_idx", 32'(cell_idx), 32'h0);
    check("rst_ram", 32'(cell_ram), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    start = 1'b0; cfg_valid = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", 32'(busy), 32'h0);

    // Full pass, valid held high, words 0..F.
    for (int i = 0; i < N; i++) wds[i] = RW'(i);
    run_pass(100, -1, 0, -1, -1, 0, lat, ab);
    check("full_latency", 32'(lat), 32'd66);
    check_pass("full");
    for (int k = 1; k < N && k < s_edge.size(); k++)
      check("full_spacing", 32'(s_edge[k] - s_edge[k-1]), 32'd4);
`ifdef CFG_READBACK_EN
    rd_idx = 4'd9;
    @(negedge clk);
    check("rb_idx9", 32'(rd_data), 32'h9);
    rd_idx = 4'd15;
    @(negedge clk);
    check("rb_idx15", 32'(rd_data), 32'hF);
`endif

    // Stall before cell 5 for 10 cycles, stray start at cell 7.
    for (int i = 0; i < N; i++) wds[i] = RW'($urandom);
    run_pass(100, 5, 10, 7, -1, 0, lat, ab);
    check("stall_latency", 32'(lat), 32'd76);
    check_pass("stall");
    if (s_edge.size() == N) check("stall_gap", 32'(s_edge[5] - s_edge[4]), 32'd14);

    // Reset on the SETUP->STROBE edge of cell 3, then a clean pass.
    run_pass(100, -1, 0, -1, 3, 0, lat, ab);
    check("abort_taken", 32'(ab), 32'h1);
    check("abort_strobes", 32'(s_idx.size()), 32'd3);
    @(negedge clk);
    run_pass(100, -1, 0, -1, -1, 0, lat, ab);
    if (s_idx.size() > 0) check("restart_first_bit", 32'(s_idx[0]), 32'h0);
    check_pass("restart");

    // Randomized passes: sporadic valid, stray starts while busy.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < N; i++) wds[i] = RW'($urandom);
      run_pass(int'($urandom_range(100, 30)), -1, 0, -1, -1, 5, lat, ab);
      check_pass("random");
      repeat (int'($urandom_range(4))) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
